fastfloor_q_to_bba: RTL
=======================

// Module: fastfloor_q_to_BBa
// PURPOSE
//  BEHZ "divide by q and floor" stage of BFV ciphertext multiply. Sits directly upstream of
//  fastBConvEx_BBa_to_q: takes tensored (t-scaled) residues in q U BBa and returns
//  y = (x_BBa - fastBConv_q->BBa(x_q)) * q^-1 mod BBa. Lane order matches what fastBConvEx expects:
//  B moduli first, Ba last. Single-issue, multi-cycle, valid/ready on input, one-cycle valid pulse on output.
// PARAMETERS
//  IN_q_LEN    `q_BASIS_LEN    number of q residues at the head of each input slot
//  OUT_LEN     `BBa_BASIS_LEN  number of BBa residues at the tail of each input slot and in the output
//  OUT_BASIS   BBa_BASIS       moduli m[j] of the output basis (B then Ba)
//  QINV        qinv_MOD_BBa    LUT: q^-1 mod m[j], j=0..OUT_LEN-1
// PORTS
//  clk             in   1                             clock
//  reset_n         in   1                             async active-low reset
//  in_valid        in   1                             input_RNSpoly valid; accepted only when in_ready=1
//  in_ready        out  1                             block idle, can accept
//  input_RNSpoly   in   [N_SLOTS][IN_q_LEN+OUT_LEN] x RNS_PRIME_BITS  q residues [0..IN_q_LEN-1], then BBa
//  out_valid       out  1                             one-cycle pulse, output_RNSpoly holds a new result
//  output_RNSpoly  out  [N_SLOTS][OUT_LEN] x RNS_PRIME_BITS    y residues; held until next result
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, in_ready=1, out_valid=0, output_RNSpoly=0, captured x_BBa=0.
//    Internal fastBConv q->BBa (ZiLUT z_MOD_q, YMODB y_q_TO_BBa) is driven with reset = ~reset_n.
//  - FSM IDLE -> CONV -> IDLE.
//    IDLE: in_ready=1. On in_valid: capture x_BBa lanes into regs, pulse the conv in_valid, go to CONV.
//    CONV: in_ready=0. in_valid is ignored, with no capture and no restart. On conv out_valid:
//    register y into output_RNSpoly, assert out_valid on the next cycle, return to IDLE.
//  - Latency: L_conv + 1 cycles from accepted in_valid to out_valid (L_conv = fastBConv in->out latency).
//  - out_valid is asserted in the first IDLE cycle, so a new in_valid in that same cycle is accepted.
//    Back-to-back throughput is one result per L_conv+1 cycles.
//  - Per slot k, lane j, with c = conv output:
//    d = x[k][j] - c[k][j]   signed RNS_PRIME_BITS+1 bits; if negative, d += m[j]
//    p = d * QINV[j]         2*RNS_PRIME_BITS bits
//    y = p % m[j]
//    Inputs are < m[j]; output always lies in [0, m[j]-1].
//  - x_BBa regs update only on accepted in_valid. Output regs update only on conv completion.
//  - reset_n low in mid-CONV aborts the operation: no out_valid, outputs return to 0.
//  - Elaboration $fatal if IN_q_LEN+OUT_LEN != `q_BASIS_LEN+`BBa_BASIS_LEN.
// CONFIGURATION
//  FASTFLOOR_OUT_REG_EN defined:
//    extra register stage after the modular multiply (mult and % split over two cycles).
//    Latency = L_conv + 2; out_valid and data move together; in_ready stays low through the extra stage.
//  FASTFLOOR_OUT_REG_EN undefined:
//    single stage as described above; latency L_conv + 1.
// TESTING
//  1 Exact multiple: x_q=0 all lanes, x_BBa[j] = (7*q) mod m[j], all slots -> out_valid after L_conv+1;
//    y=7 every slot/lane.
//  2 Zero input: all residues 0 -> y=0 everywhere; exactly one out_valid pulse.
//  3 Wrap: choose x_q so conv c[k][j] > x_BBa[k][j] -> y = ((x-c+m)*QINV[j]) % m[j]
//    (check against C model); no value >= m[j].
//  4 Busy drop: in_valid held high with input A, then B during CONV -> only A's result appears;
//    B is accepted at the out_valid cycle; its result follows L_conv+1 cycles later.
//  5 Reset mid-op: pull reset_n low 2 cycles after acceptance -> out_valid never pulses,
//    output_RNSpoly=0, in_ready=1 after release.
//  6 Macro: rerun test 1 with FASTFLOOR_OUT_REG_EN -> same y=7, out_valid delayed by exactly 1 cycle.

Source files
------------

// File: rtl/fastfloor_q_to_bba.sv
// BEHZ divide-by-q-and-floor: y = (x_BBa - fastBConv_q->BBa(x_q)) * q^-1 mod BBa, per slot and lane.
// Optional FASTFLOOR_OUT_REG_EN splits the multiply and the reduction across two cycles.
`ifndef q_BASIS_LEN
`define q_BASIS_LEN 2
`endif
`ifndef BBa_BASIS_LEN
`define BBa_BASIS_LEN 3
`endif

module fastfloor_q_to_bba #(
    parameter int RNS_PRIME_BITS = 8,
    parameter int N_SLOTS        = 2,
    parameter int IN_q_LEN       = `q_BASIS_LEN,
    parameter int OUT_LEN        = `BBa_BASIS_LEN,
    parameter logic [IN_q_LEN-1:0][RNS_PRIME_BITS-1:0] Q_BASIS =
        {RNS_PRIME_BITS'(17), RNS_PRIME_BITS'(13)},
    parameter logic [OUT_LEN-1:0][RNS_PRIME_BITS-1:0] OUT_BASIS =
        {RNS_PRIME_BITS'(29), RNS_PRIME_BITS'(23), RNS_PRIME_BITS'(19)},
    parameter logic [OUT_LEN-1:0][RNS_PRIME_BITS-1:0] QINV =
        {RNS_PRIME_BITS'(21), RNS_PRIME_BITS'(5), RNS_PRIME_BITS'(8)},
    parameter logic [IN_q_LEN-1:0][RNS_PRIME_BITS-1:0] Z_MOD_Q =
        {RNS_PRIME_BITS'(4), RNS_PRIME_BITS'(10)},
    parameter logic [IN_q_LEN-1:0][OUT_LEN-1:0][RNS_PRIME_BITS-1:0] Y_Q_TO_BBA =
        {{RNS_PRIME_BITS'(13), RNS_PRIME_BITS'(13), RNS_PRIME_BITS'(13)},
         {RNS_PRIME_BITS'(17), RNS_PRIME_BITS'(17), RNS_PRIME_BITS'(17)}}
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [N_SLOTS*(IN_q_LEN+OUT_LEN)*RNS_PRIME_BITS-1:0] input_RNSpoly,
    output logic out_valid,
    output logic [N_SLOTS*OUT_LEN*RNS_PRIME_BITS-1:0] output_RNSpoly
);
    // state  | meaning
    // S_IDLE | ready; accepts in_valid, captures x_BBa, launches the base conversion
    // S_CONV | waiting for the base conversion; in_valid ignored
    // S_OREG | reduction stage of the split multiply (FASTFLOOR_OUT_REG_EN only)

    localparam int W  = RNS_PRIME_BITS;
    localparam int NL = IN_q_LEN + OUT_LEN;
    localparam int SW = 2*W + $clog2(IN_q_LEN+1);

    if (IN_q_LEN + OUT_LEN != `q_BASIS_LEN + `BBa_BASIS_LEN) begin : g_len_chk
        $fatal(1, "fastfloor_q_to_bba: IN_q_LEN+OUT_LEN does not match basis lengths");
    end

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_OREG} state_t;

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % {{W{1'b0}}, m});
    endfunction

    state_t state_q, state_d;
    logic   conv_in_vld, conv_v1_q, conv_v1_d, conv_v2_q, conv_v2_d;
    logic   conv_done, out_valid_q, out_valid_d;

    logic [N_SLOTS-1:0][IN_q_LEN-1:0][W-1:0] z_q, z_d;
    logic [N_SLOTS-1:0][OUT_LEN-1:0][W-1:0]  c_q, c_d;
    logic [N_SLOTS-1:0][OUT_LEN-1:0][W-1:0]  xbba_q, xbba_d;
    logic [N_SLOTS-1:0][OUT_LEN-1:0][W-1:0]  diff, y_new;
    logic [N_SLOTS-1:0][OUT_LEN-1:0][W-1:0]  out_q, out_d;

    assign conv_in_vld = in_valid & in_ready;
    assign conv_done   = (state_q == S_CONV) & conv_v2_q;

    // Base conversion q->BBa: z = x*ZiLUT mod q_i, then c = sum z*YMODB mod m_j.
    always_comb begin
        logic [SW-1:0] acc;
        z_d       = z_q;
        c_d       = c_q;
        xbba_d    = xbba_q;
        conv_v1_d = conv_in_vld;
        conv_v2_d = conv_v1_q;
        acc       = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (conv_in_vld) begin
                for (int i = 0; i < IN_q_LEN; i++)
                    z_d[k][i] = mul_mod(input_RNSpoly[(k*NL+i)*W +: W], Z_MOD_Q[i], Q_BASIS[i]);
                for (int j = 0; j < OUT_LEN; j++)
                    xbba_d[k][j] = input_RNSpoly[(k*NL+IN_q_LEN+j)*W +: W];
            end
            if (conv_v1_q) begin
                for (int j = 0; j < OUT_LEN; j++) begin
                    acc = '0;
                    for (int i = 0; i < IN_q_LEN; i++)
                        acc = acc + SW'({{W{1'b0}}, z_q[k][i]} * {{W{1'b0}}, Y_Q_TO_BBA[i][j]});
                    c_d[k][j] = W'(acc % SW'(OUT_BASIS[j]));
                end
            end
        end
    end

    // Modular difference, brought back into [0, m) when it goes negative.
    always_comb begin
        logic [W:0] dd;
        diff = '0;
        dd   = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            for (int j = 0; j < OUT_LEN; j++) begin
                dd = {1'b0, xbba_q[k][j]} - {1'b0, c_q[k][j]};
                if (dd[W])
                    dd = dd + {1'b0, OUT_BASIS[j]};
                diff[k][j] = dd[W-1:0];
            end
        end
    end

`ifdef FASTFLOOR_OUT_REG_EN
    logic [N_SLOTS-1:0][OUT_LEN-1:0][2*W-1:0] p_q, p_d;

    always_comb begin
        p_d   = p_q;
        y_new = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            for (int j = 0; j < OUT_LEN; j++) begin
                if (conv_done)
                    p_d[k][j] = {{W{1'b0}}, diff[k][j]} * {{W{1'b0}}, QINV[j]};
                y_new[k][j] = W'(p_q[k][j] % {{W{1'b0}}, OUT_BASIS[j]});
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p_q <= '0;
        else          p_q <= p_d;
    end
`else
    always_comb begin
        y_new = '0;
        for (int k = 0; k < N_SLOTS; k++)
            for (int j = 0; j < OUT_LEN; j++)
                y_new[k][j] = mul_mod(diff[k][j], QINV[j], OUT_BASIS[j]);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_CONV;
`ifdef FASTFLOOR_OUT_REG_EN
            S_CONV: if (conv_v2_q) state_d = S_OREG;
            S_OREG: state_d = S_IDLE;
`else
            S_CONV: if (conv_v2_q) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
`ifdef FASTFLOOR_OUT_REG_EN
        out_valid_d = (state_q == S_OREG);
`else
        out_valid_d = conv_done;
`endif
        out_d = out_valid_d ? y_new : out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            conv_v1_q   <= 1'b0;
            conv_v2_q   <= 1'b0;
            z_q         <= '0;
            c_q         <= '0;
            xbba_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_v1_q   <= conv_v1_d;
            conv_v2_q   <= conv_v2_d;
            z_q         <= z_d;
            c_q         <= c_d;
            xbba_q      <= xbba_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign output_RNSpoly = out_q;

endmodule
